ntt_poly_buffer: RTL and testbench
==================================

Name: ntt_poly_buffer

Overview:
- Multi-slot polynomial buffer that sits in front of `ntt_memory_wrapper` and serves its read/write address port.
- Generalises the single-polynomial memory model behind the NTT core into `NBANK` ring-ordered slots.
- Slots are loaded from a host stream, transformed forward or inverse per slot, and unloaded to a host stream.
- Loading, transforming and unloading of different slots overlap.

Parameters:
- LOGQ, 64, coefficient width in bits.
- LOGN, 4, log2 of polynomial length; N = 2**LOGN.
- NBANK, 2, number of polynomial slots, 2..8.
- DELAY_BRAM, 1, NTT-side read latency in cycles (1 or 2).
- AW, ((LOGN<9)?9:LOGN)+1, width of the NTT address ports.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ld_valid  in  1  host load beat valid
- ld_ready  out  1  load beat accepted when valid&ready
- ld_data  in  LOGQ  coefficient, natural order 0..N-1
- ld_last  in  1  host marks beat N-1
- ld_intt  in  1  mode for the slot, sampled on its first beat; 1 = inverse
- ul_valid  out  1  unload beat valid
- ul_ready  in  1  host accepts unload beat
- ul_data  out  LOGQ  result coefficient, natural order
- ul_last  out  1  high on beat N-1
- ntt_start  out  1  level start to the NTT wrapper
- ntt_intt  out  1  mode of the slot being transformed
- ntt_btf_gs  out  1  equals ntt_intt
- ntt_finish  in  1  finish from the NTT wrapper
- read_address  in  AW  NTT read index
- write_address  in  AW  NTT write index
- wea  in  1  NTT write enable
- data_in_0, data_in_1  out  LOGQ  src[ra], src[ra+N/2]
- data_out_0, data_out_1  in  LOGQ  written to dst[wa], dst[wa+N/2]
- ld_err  out  1  sticky: `ld_last` was misplaced

Behaviour:
- Per slot: a src array and a dst array, N×LOGQ each, plus state FREE/LOADED/BUSY/DONE and a mode bit.
- Three pointers ld_ptr, ntt_ptr, ul_ptr each increment mod NBANK on slot completion, so slots are strictly FIFO-ordered.

Load path:
- `ld_ready` = state[ld_ptr]==FREE.
- Each accepted beat writes src[ld_ptr][ld_cnt] and increments `ld_cnt`.
- On beat N-1: `ld_cnt`→0, state→LOADED, ld_ptr advances. The next slot's `ld_ready` rises the following cycle if that slot is FREE.
- `ld_last` asserted on a beat ≠ N-1, or deasserted on beat N-1, sets `ld_err`. Slot completion still uses only `ld_cnt`.

NTT FSM (IDLE → RUN → WAIT_LOW):
- IDLE: if state[ntt_ptr]==LOADED, go to RUN next cycle and set state→BUSY. `ntt_start`=1 and `ntt_intt`=mode are registered.
- RUN: `ntt_start` held high. On the first cycle `ntt_finish`=1, drop `ntt_start` next cycle, set state→DONE, advance ntt_ptr, go to WAIT_LOW.
- WAIT_LOW: return to IDLE once `ntt_finish`=0.
- `ntt_finish` is ignored in IDLE.
- NTT port addressing uses read_address[LOGN-2:0] and write_address[LOGN-2:0]; upper bits are ignored.
- `data_in_*` come from src of the BUSY slot with exactly DELAY_BRAM cycles latency; they hold their previous value when no slot is BUSY.
- `wea` writes dst of the BUSY slot; `wea` while no slot is BUSY is dropped.

Unload path:
- Reads dst[ul_ptr] in natural order through a 2-entry output FIFO, so `ul_valid`/`ul_data` are registered and an upstream stall never drops data.
- Unload is enabled while state[ul_ptr]==DONE. First `ul_valid` appears 2 cycles after DONE.
- `ul_data`/`ul_last` are held stable while `ul_valid` & !`ul_ready`.
- After beat N-1 is accepted: state→FREE, ul_ptr advances.

Simultaneous events:
- Load completion, NTT completion and unload completion in the same cycle act on distinct slots and all take effect.
- A slot freed by unload in cycle t may be loaded from cycle t+1.

Full and empty:
- All slots non-FREE → `ld_ready`=0.
- No DONE slot → `ul_valid`=0.

Reset:
- Asynchronous, any time, including mid-transform or mid-unload. All states FREE, pointers and counters 0, FSM IDLE, output FIFO empty.
- Outputs after reset: `ntt_start`=0, `ntt_intt`=0, `ntt_btf_gs`=0, `ld_ready`=1, `ul_valid`=0, `ul_last`=0, `ul_data`=0, `data_in_*`=0, `ld_err`=0.
- Array contents are not cleared.

Test Plan (LOGN=4, N=16, NBANK=2, LOGQ=64, Q=9223372036855300097, NTT wrapper instantiated as DUT partner):
- Load the NTT_DIN.mem vector with `ld_intt`=0 → `ntt_start` rises 2 cycles after beat 15. The unloaded 16 words equal NTT_DOUT.mem; `ul_last` is high on word 15 only.
- Load INTT_DIN.mem with `ld_intt`=1 → `ntt_intt`=`ntt_btf_gs`=1 during RUN. The output equals INTT_DOUT.mem.
- Load three polynomials back-to-back with `ul_ready`=0 → the third load stalls (`ld_ready`=0) after two slots fill. Raising `ul_ready` drains slot 0 first; the third load then completes, and the outputs come back in input order.
- Randomly toggle `ul_ready` (50%) during an unload → exactly 16 beats, no duplicates or losses, `ul_data` stable across stalls.
- `ld_last`=1 on beat 7 → `ld_err`=1 and stays 1. The slot still completes on beat 15 with correct NTT output.
- Assert `rst` during RUN at cycle 20 of a transform → the same cycle gives `ntt_start`=0, `ld_ready`=1, `ul_valid`=0. A fresh load then produces a correct NTT_DOUT.mem result.

Source files
------------

// File: rtl/ntt_poly_buffer.sv
// Multi-slot polynomial buffer in front of the NTT wrapper.
// Slots are loaded from a host stream, transformed in FIFO order through the
// wrapper's address port, and unloaded in natural order through a 2-entry FIFO.
module ntt_poly_buffer #(
    parameter int LOGQ       = 64,
    parameter int LOGN       = 4,
    parameter int NBANK      = 2,
    parameter int DELAY_BRAM = 1,
    parameter int AW         = ((LOGN < 9) ? 9 : LOGN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [LOGQ-1:0] ld_data,
    input  logic            ld_last,
    input  logic            ld_intt,
    output logic            ul_valid,
    input  logic            ul_ready,
    output logic [LOGQ-1:0] ul_data,
    output logic            ul_last,
    output logic            ntt_start,
    output logic            ntt_intt,
    output logic            ntt_btf_gs,
    input  logic            ntt_finish,
    input  logic [AW-1:0]   read_address,
    input  logic [AW-1:0]   write_address,
    input  logic            wea,
    output logic [LOGQ-1:0] data_in_0,
    output logic [LOGQ-1:0] data_in_1,
    input  logic [LOGQ-1:0] data_out_0,
    input  logic [LOGQ-1:0] data_out_1,
    output logic            ld_err
);

    localparam int N  = 1 << LOGN;
    localparam int PW = $clog2(NBANK);

    typedef enum logic [1:0] {S_FREE, S_LOADED, S_BUSY, S_DONE} slot_st_t;
    typedef enum logic [1:0] {F_IDLE, F_RUN, F_WAIT_LOW} fsm_t;

    logic [LOGQ-1:0] src_mem [NBANK][N];
    logic [LOGQ-1:0] dst_mem [NBANK][N];
    slot_st_t        slot_st [NBANK];
    logic [NBANK-1:0] slot_mode;

    logic [PW-1:0]   ld_ptr, ntt_ptr, ul_ptr;
    logic [LOGN-1:0] ld_cnt;
    logic [LOGN:0]   ul_cnt;

    fsm_t            fsm_q, fsm_d;
    logic            ntt_go, ntt_fin, ntt_busy, ntt_mode_q;

    logic            ld_fire, ld_at_end, ld_end;
    logic [LOGN-2:0] ra, wa;
    logic            unused_addr_bits;

    logic [LOGQ-1:0] s0_0, s0_1, s1_0, s1_1;
    logic            busy_d;

    logic            rd_valid, rd_last, ul_issue, ul_pop, ul_end;
    logic [LOGQ-1:0] rd_data;
    logic [LOGQ-1:0] fifo_data [2];
    logic [1:0]      fifo_last;
    logic            wr_ptr, rd_ptr;
    logic [1:0]      fifo_cnt;
    logic [2:0]      occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NBANK - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ra = read_address[LOGN-2:0];
    assign wa = write_address[LOGN-2:0];
    assign unused_addr_bits = ^{read_address[AW-1:LOGN-1], write_address[AW-1:LOGN-1]};

    assign ld_ready  = (slot_st[ld_ptr] == S_FREE);
    assign ld_fire   = ld_valid & ld_ready;
    assign ld_at_end = (ld_cnt == LOGN'(N - 1));
    assign ld_end    = ld_fire & ld_at_end;

    // Load side: beat counter, slot mode capture, misplaced-last detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_ptr    <= '0;
            ld_cnt    <= '0;
            ld_err    <= 1'b0;
            slot_mode <= '0;
        end else if (ld_fire) begin
            if (ld_cnt == '0)
                slot_mode[ld_ptr] <= ld_intt;
            if (ld_last != ld_at_end)
                ld_err <= 1'b1;
            if (ld_at_end) begin
                ld_cnt <= '0;
                ld_ptr <= ptr_inc(ld_ptr);
            end else begin
                ld_cnt <= ld_cnt + 1'b1;
            end
        end
    end

    // Slot lifecycle; each event requires a distinct current state, so the
    // four updates always target distinct slots and never collide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NBANK; i++)
                slot_st[i] <= S_FREE;
        end else begin
            if (ld_end)   slot_st[ld_ptr]  <= S_LOADED;
            if (ntt_go)   slot_st[ntt_ptr] <= S_BUSY;
            if (ntt_fin)  slot_st[ntt_ptr] <= S_DONE;
            if (ul_end)   slot_st[ul_ptr]  <= S_FREE;
        end
    end

    // NTT FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm_q <= F_IDLE;
        else     fsm_q <= fsm_d;
    end

    // NTT FSM next-state logic
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            F_IDLE:     if (slot_st[ntt_ptr] == S_LOADED) fsm_d = F_RUN;
            F_RUN:      if (ntt_finish)                   fsm_d = F_WAIT_LOW;
            F_WAIT_LOW: if (!ntt_finish)                  fsm_d = F_IDLE;
            default:                                      fsm_d = F_IDLE;
        endcase
    end

    // NTT FSM outputs and event strobes
    always_comb begin
        ntt_go    = (fsm_q == F_IDLE) && (slot_st[ntt_ptr] == S_LOADED);
        ntt_fin   = (fsm_q == F_RUN) && ntt_finish;
        ntt_busy  = (fsm_q == F_RUN);
        ntt_start = ntt_busy;
    end

    // Transform pointer and registered mode of the slot being transformed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ntt_ptr    <= '0;
            ntt_mode_q <= 1'b0;
        end else begin
            if (ntt_go)  ntt_mode_q <= slot_mode[ntt_ptr];
            if (ntt_fin) ntt_ptr    <= ptr_inc(ntt_ptr);
        end
    end

    assign ntt_intt   = ntt_mode_q;
    assign ntt_btf_gs = ntt_mode_q;

    // Coefficient storage writes (contents survive reset)
    always_ff @(posedge clk) begin
        if (ld_fire)
            src_mem[ld_ptr][ld_cnt] <= ld_data;
        if (wea && ntt_busy) begin
            dst_mem[ntt_ptr][{1'b0, wa}] <= data_out_0;
            dst_mem[ntt_ptr][{1'b1, wa}] <= data_out_1;
        end
    end

    // NTT read pipeline; stages only advance while a slot is busy so the
    // outputs hold their last value otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_0   <= '0;
            s0_1   <= '0;
            s1_0   <= '0;
            s1_1   <= '0;
            busy_d <= 1'b0;
        end else begin
            busy_d <= ntt_busy;
            if (ntt_busy) begin
                s0_0 <= src_mem[ntt_ptr][{1'b0, ra}];
                s0_1 <= src_mem[ntt_ptr][{1'b1, ra}];
            end
            if (busy_d) begin
                s1_0 <= s0_0;
                s1_1 <= s0_1;
            end
        end
    end

    assign data_in_0 = (DELAY_BRAM == 2) ? s1_0 : s0_0;
    assign data_in_1 = (DELAY_BRAM == 2) ? s1_1 : s0_1;

    // Unload read issue: in-flight read plus FIFO occupancy, net of this
    // cycle's pop, must leave room so a stalled host never loses a beat
    always_comb begin
        ul_pop   = ul_valid & ul_ready;
        occ      = {1'b0, fifo_cnt} + {2'b0, rd_valid} - {2'b0, ul_pop};
        ul_issue = (slot_st[ul_ptr] == S_DONE) && (ul_cnt != (LOGN + 1)'(N)) && (occ < 3'd2);
        ul_end   = ul_pop & ul_last;
    end

    // Unload result memory read stage
    always_ff @(posedge clk) begin
        if (ul_issue)
            rd_data <= dst_mem[ul_ptr][ul_cnt[LOGN-1:0]];
    end

    // Unload counters and 2-entry output FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ul_ptr    <= '0;
            ul_cnt    <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= '0;
        end else begin
            rd_valid <= ul_issue;
            rd_last  <= ul_issue && (ul_cnt == (LOGN + 1)'(N - 1));
            if (ul_end) begin
                ul_cnt <= '0;
                ul_ptr <= ptr_inc(ul_ptr);
            end else if (ul_issue) begin
                ul_cnt <= ul_cnt + 1'b1;
            end
            if (rd_valid) begin
                fifo_data[wr_ptr] <= rd_data;
                fifo_last[wr_ptr] <= rd_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (ul_pop)
                rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, rd_valid} - {1'b0, ul_pop};
        end
    end

    assign ul_valid = (fifo_cnt != 2'd0);
    assign ul_data  = fifo_data[rd_ptr];
    assign ul_last  = ul_valid & fifo_last[rd_ptr];

endmodule

// File: tb/tb_ntt_poly_buffer.sv
// Self-checking bench for ntt_poly_buffer with a behavioural NTT partner that
// applies a simple butterfly over (i, i+N/2) pairs through the address port.
module tb_ntt_poly_buffer;

    localparam int LOGQ = 64;
    localparam int LOGN = 4;
    localparam int N    = 16;
    localparam int NB   = 2;
    localparam int DB   = 1;
    localparam int AW   = 10;

    logic            clk, rst;
    logic            ld_valid, ld_ready, ld_last, ld_intt;
    logic [LOGQ-1:0] ld_data;
    logic            ul_valid, ul_ready, ul_last;
    logic [LOGQ-1:0] ul_data;
    logic            ntt_start, ntt_intt, ntt_btf_gs, ntt_finish, wea;
    logic [AW-1:0]   read_address, write_address;
    logic [LOGQ-1:0] data_in_0, data_in_1, data_out_0, data_out_1;
    logic            ld_err;

    int checks   = 0;
    int failures = 0;

    logic [64:0] sc_q [$];
    bit          mode_q [$];
    bit          hold = 1'b0;
    bit          rnd  = 1'b0;

    ntt_poly_buffer #(.LOGQ(LOGQ), .LOGN(LOGN), .NBANK(NB), .DELAY_BRAM(DB), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .ld_last(ld_last), .ld_intt(ld_intt),
        .ul_valid(ul_valid), .ul_ready(ul_ready), .ul_data(ul_data), .ul_last(ul_last),
        .ntt_start(ntt_start), .ntt_intt(ntt_intt), .ntt_btf_gs(ntt_btf_gs),
        .ntt_finish(ntt_finish), .read_address(read_address),
        .write_address(write_address), .wea(wea),
        .data_in_0(data_in_0), .data_in_1(data_in_1),
        .data_out_0(data_out_0), .data_out_1(data_out_1),
        .ld_err(ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bf0(input logic [63:0] a, input logic [63:0] b, input bit inv);
        return inv ? (a ^ b) : (a + b);
    endfunction

    function automatic logic [63:0] bf1(input logic [63:0] a, input logic [63:0] b, input bit inv);
        return inv ? ((a << 1) + b) : (a - b);
    endfunction

    // Host load of one polynomial; expected unload words go to the scoreboard
    task automatic load_poly(input bit inv, input int bad_last);
        logic [63:0] c [N];
        logic [63:0] o [N];
        int wt;
        for (int k = 0; k < N; k++) c[k] = {$urandom, $urandom};
        for (int i = 0; i < N / 2; i++) begin
            o[i]       = bf0(c[i], c[i + N / 2], inv);
            o[i + N/2] = bf1(c[i], c[i + N / 2], inv);
        end
        for (int k = 0; k < N; k++) sc_q.push_back({(k == N - 1), o[k]});
        mode_q.push_back(inv);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_data  = c[k];
            ld_last  = (k == N - 1) || (k == bad_last);
            ld_intt  = inv;
            wt = 0;
            while (!ld_ready && wt < 3000) begin
                @(negedge clk);
                wt++;
            end
            check1("ld_accept", ld_ready, 1'b1);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int wt = 0;
        while (sc_q.size() != 0 && wt < 600) begin
            @(negedge clk);
            wt++;
        end
        check64("drain_left", 64'(sc_q.size()), 64'd0);
    endtask

    // NTT partner: reads pairs, writes butterflies, then pulses finish
    initial begin
        logic [63:0] a, b;
        bit pm, em;
        int wt;
        ntt_finish = 1'b0;
        wea = 1'b0;
        read_address = '0;
        write_address = '0;
        data_out_0 = '0;
        data_out_1 = '0;
        forever begin
            @(negedge clk);
            if (ntt_start && !rst) begin
                pm = ntt_intt;
                if (mode_q.size() > 0) begin
                    em = mode_q.pop_front();
                    check1("ntt_intt", ntt_intt, em);
                    check1("ntt_btf_gs", ntt_btf_gs, em);
                end
                repeat (6) @(negedge clk);
                for (int i = 0; i < N / 2; i++) begin
                    read_address = AW'(i);
                    repeat (DB) @(negedge clk);
                    a = data_in_0;
                    b = data_in_1;
                    write_address = AW'(i);
                    data_out_0 = bf0(a, b, pm);
                    data_out_1 = bf1(a, b, pm);
                    wea = 1'b1;
                    @(negedge clk);
                    wea = 1'b0;
                end
                ntt_finish = 1'b1;
                wt = 0;
                do begin
                    @(negedge clk);
                    wt++;
                end while (ntt_start && wt < 20);
                check1("ntt_start_drop", ntt_start, 1'b0);
                ntt_finish = 1'b0;
            end
        end
    end

    // Unload monitor: drives ul_ready, pops the scoreboard, checks stall hold
    initial begin
        logic [64:0] e;
        logic [63:0] prev_data;
        bit prev_stall;
        ul_ready = 1'b0;
        prev_stall = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check1("ul_hold_valid", ul_valid, 1'b1);
                    check64("ul_hold_data", ul_data, prev_data);
                end
                ul_ready = hold ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
                if (ul_valid && ul_ready) begin
                    if (sc_q.size() == 0) begin
                        check1("ul_unexpected_beat", ul_valid, 1'b0);
                    end else begin
                        e = sc_q.pop_front();
                        check64("ul_data", ul_data, e[63:0]);
                        check1("ul_last", ul_last, e[64]);
                    end
                end
                prev_stall = ul_valid && !ul_ready;
                prev_data  = ul_data;
            end
        end
    end

    // Directed sequence
    initial begin
        int wt;
        rst = 1'b1;
        ld_valid = 1'b0;
        ld_data = '0;
        ld_last = 1'b0;
        ld_intt = 1'b0;
        repeat (3) @(negedge clk);
        check1("rst_ntt_start", ntt_start, 1'b0);
        check1("rst_ntt_intt", ntt_intt, 1'b0);
        check1("rst_btf_gs", ntt_btf_gs, 1'b0);
        check1("rst_ld_ready", ld_ready, 1'b1);
        check1("rst_ul_valid", ul_valid, 1'b0);
        check1("rst_ul_last", ul_last, 1'b0);
        check64("rst_ul_data", ul_data, 64'd0);
        check64("rst_din0", data_in_0, 64'd0);
        check64("rst_din1", data_in_1, 64'd0);
        check1("rst_ld_err", ld_err, 1'b0);
        rst = 1'b0;

        // forward transform and start latency
        load_poly(1'b0, -1);
        check1("start_lat_c1", ntt_start, 1'b0);
        @(negedge clk);
        check1("start_lat_c2", ntt_start, 1'b1);
        wait_drain();

        // inverse transform
        load_poly(1'b1, -1);
        wait_drain();

        // full buffer with the host stalled, then drain in order
        hold = 1'b1;
        load_poly(1'b0, -1);
        load_poly(1'b1, -1);
        check1("full_ld_ready", ld_ready, 1'b0);
        repeat (80) @(negedge clk);
        check1("full_ld_ready_late", ld_ready, 1'b0);
        check1("full_ul_valid", ul_valid, 1'b1);
        hold = 1'b0;
        load_poly(1'b0, -1);
        wait_drain();

        // random host backpressure
        rnd = 1'b1;
        load_poly(1'b1, -1);
        wait_drain();
        rnd = 1'b0;

        // misplaced last on beat 7
        check1("ld_err_before", ld_err, 1'b0);
        load_poly(1'b0, 7);
        check1("ld_err_set", ld_err, 1'b1);
        wait_drain();
        check1("ld_err_sticky", ld_err, 1'b1);

        // reset in the middle of a transform
        load_poly(1'b0, -1);
        wt = 0;
        while (!ntt_start && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        check1("run_seen", ntt_start, 1'b1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check1("mid_rst_ntt_start", ntt_start, 1'b0);
        check1("mid_rst_ld_ready", ld_ready, 1'b1);
        check1("mid_rst_ul_valid", ul_valid, 1'b0);
        check1("mid_rst_ld_err", ld_err, 1'b0);
        sc_q.delete();
        mode_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        load_poly(1'b0, -1);
        wait_drain();
        repeat (4) @(negedge clk);
        check1("end_ld_ready", ld_ready, 1'b1);
        check1("end_ul_valid", ul_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
